// File: rtl/idct_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idct_pkg : shared constants for the 4-point HEVC inverse DCT slice    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package idct_pkg;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;

  localparam logic PASS_ROW = 1'b0;
  localparam logic PASS_COL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/idct_round_clip.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idct_round_clip : round-half-up, arithmetic shift and saturate        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module idct_round_clip
  import idct_pkg::*;
#(
  parameter int ACC_W  = 25,
  parameter int OUT_W  = 16,
  parameter int SHIFT0 = 7,
  parameter int SHIFT1 = 12
) (
  input  logic signed [ACC_W-1:0] s,
  input  logic                    pass,
  output logic signed [OUT_W-1:0] y
);

  localparam logic signed [ACC_W:0] c_rnd0 = {{ACC_W{1'b0}}, 1'b1} << (SHIFT0 - 1);
  localparam logic signed [ACC_W:0] c_rnd1 = {{ACC_W{1'b0}}, 1'b1} << (SHIFT1 - 1);
  localparam logic signed [ACC_W:0] c_max  = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] c_min  = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // One guard bit so adding the rounding constant can never wrap.
  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_sum0;
  logic signed [ACC_W:0] w_sum1;
  logic signed [ACC_W:0] w_shr;

  assign w_ext  = {s[ACC_W-1], s};
  assign w_sum0 = w_ext + c_rnd0;
  assign w_sum1 = w_ext + c_rnd1;
  assign w_shr  = (pass == PASS_COL) ? (w_sum1 >>> SHIFT1) : (w_sum0 >>> SHIFT0);

  always_comb begin
    if (w_shr > c_max) begin
      y = c_max[OUT_W-1:0];
    end else if (w_shr < c_min) begin
      y = c_min[OUT_W-1:0];
    end else begin
      y = w_shr[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/idct4_row_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idct4_row_pipe : 3-stage 4-point HEVC inverse DCT, valid/ready stall  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module idct4_row_pipe
  import idct_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 25,
  parameter int SHIFT0 = 7,
  parameter int SHIFT1 = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_pass,
  input  logic signed [IN_W-1:0]  x0,
  input  logic signed [IN_W-1:0]  x1,
  input  logic signed [IN_W-1:0]  x2,
  input  logic signed [IN_W-1:0]  x3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_pass,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3
);

  localparam logic signed [ACC_W-1:0] c_64 = ACC_W'(C64);
  localparam logic signed [ACC_W-1:0] c_83 = ACC_W'(C83);
  localparam logic signed [ACC_W-1:0] c_36 = ACC_W'(C36);

  logic                    w_en;
  logic signed [ACC_W-1:0] w_x0e, w_x1e, w_x2e, w_x3e;
  logic signed [OUT_W-1:0] w_y [4];

  logic                    r_v1, r_v2, r_v3;
  logic                    r_p1, r_p2, r_p3;
  logic signed [ACC_W-1:0] r_e0, r_e1, r_o0, r_o1;
  logic signed [ACC_W-1:0] r_s [4];
  logic signed [OUT_W-1:0] r_y [4];

  // Whole pipe advances together; a blocked output freezes every stage.
  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

  assign w_x0e = {{(ACC_W-IN_W){x0[IN_W-1]}}, x0};
  assign w_x1e = {{(ACC_W-IN_W){x1[IN_W-1]}}, x1};
  assign w_x2e = {{(ACC_W-IN_W){x2[IN_W-1]}}, x2};
  assign w_x3e = {{(ACC_W-IN_W){x3[IN_W-1]}}, x3};

  // Stage 1: even/odd partial sums
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_p1 <= PASS_ROW;
      r_e0 <= '0;
      r_e1 <= '0;
      r_o0 <= '0;
      r_o1 <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_p1 <= in_pass;
      r_e0 <= c_64 * w_x0e + c_64 * w_x2e;
      r_e1 <= c_64 * w_x0e - c_64 * w_x2e;
      r_o0 <= c_83 * w_x1e + c_36 * w_x3e;
      r_o1 <= c_36 * w_x1e - c_83 * w_x3e;
    end
  end

  // Stage 2: butterfly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v2 <= 1'b0;
      r_p2 <= PASS_ROW;
      for (int k = 0; k < 4; k++) begin
        r_s[k] <= '0;
      end
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_p2   <= r_p1;
      r_s[0] <= r_e0 + r_o0;
      r_s[1] <= r_e1 + r_o1;
      r_s[2] <= r_e1 - r_o1;
      r_s[3] <= r_e0 - r_o0;
    end
  end

  generate
    for (genvar k = 0; k < 4; k++) begin : g_rc
      idct_round_clip #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SHIFT0 (SHIFT0),
        .SHIFT1 (SHIFT1)
      ) u_rc (
        .s    (r_s[k]),
        .pass (r_p2),
        .y    (w_y[k])
      );
    end
  endgenerate

  // Stage 3: rounded, saturated result drives the outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v3 <= 1'b0;
      r_p3 <= PASS_ROW;
      for (int k = 0; k < 4; k++) begin
        r_y[k] <= '0;
      end
    end else if (w_en) begin
      r_v3 <= r_v2;
      r_p3 <= r_p2;
      for (int k = 0; k < 4; k++) begin
        r_y[k] <= w_y[k];
      end
    end
  end

  assign out_valid = r_v3;
  assign out_pass  = r_p3;
  assign y0        = r_y[0];
  assign y1        = r_y[1];
  assign y2        = r_y[2];
  assign y3        = r_y[3];

endmodule
`default_nettype wire

// File: tb/tb_idct4_row_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_idct4_row_pipe : table vectors, stall/reset sequences, random run  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_idct4_row_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, in_valid, in_ready, in_pass, out_valid, out_ready, out_pass;
  logic signed [15:0] x0, x1, x2, x3, y0, y1, y2, y3;

  idct4_row_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pass   (in_pass),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pass  (out_pass),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3)
  );

  typedef struct {
    int x[4];
    int pass;
    int y[4];
  } vec_t;

  typedef struct {
    int y[4];
    int pass;
    int cyc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_sent = 0;
  int   rdy_mode = 0;
  bit   lat_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer formula with wide arithmetic, floor shift, clamp.
  function automatic void model(input int a0, a1, a2, a3, p, output exp_t e);
    longint e0, e1, o0, o1, v;
    longint s[4];
    int sh;
    e0 = 64 * longint'(a0) + 64 * longint'(a2);
    e1 = 64 * longint'(a0) - 64 * longint'(a2);
    o0 = 83 * longint'(a1) + 36 * longint'(a3);
    o1 = 36 * longint'(a1) - 83 * longint'(a3);
    s[0] = e0 + o0;
    s[1] = e1 + o1;
    s[2] = e1 - o1;
    s[3] = e0 - o0;
    sh = (p != 0) ? 12 : 7;
    for (int k = 0; k < 4; k++) begin
      v = (s[k] + (longint'(1) << (sh - 1))) >>> sh;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      e.y[k] = int'(v);
    end
    e.pass = p;
    e.cyc  = 0;
    e.lat  = 1'b0;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pop, stall stability, in_ready during stall.
  logic        prev_hold = 1'b0;
  logic [65:0] prev_snap;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (prev_hold) begin
        chk("hold_stable", int'({y0, y1, y2, y3, out_pass, out_valid} == prev_snap), 1);
      end
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", int'(in_ready), 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y0=%0d, expected no output", y0);
        end else begin
          e = sb.pop_front();
          chk("y0", int'(y0), e.y[0]);
          chk("y1", int'(y1), e.y[1]);
          chk("y2", int'(y2), e.y[2]);
          chk("y3", int'(y3), e.y[3]);
          chk("out_pass", int'(out_pass), e.pass);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
          n_out++;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_snap = {y0, y1, y2, y3, out_pass, out_valid};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send(input int a0, a1, a2, a3, p, input exp_t e);
    int t;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x0 = 16'(a0);
    x1 = 16'(a1);
    x2 = 16'(a2);
    x3 = 16'(a3);
    in_pass = p[0];
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.cyc = cyc;
        e.lat = lat_en;
        sb.push_back(e);
        n_sent++;
        break;
      end
      t++;
      if (t > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic send_model(input int a0, a1, a2, a3, p);
    exp_t e;
    model(a0, a1, a2, a3, p, e);
    send(a0, a1, a2, a3, p, e);
  endtask

  task automatic send_vec(input vec_t v);
    exp_t e;
    e.y    = v.y;
    e.pass = v.pass;
    e.cyc  = 0;
    e.lat  = 1'b0;
    send(v.x[0], v.x[1], v.x[2], v.x[3], v.pass, e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int base;
    tbl[0] = '{x: '{64, 0, 0, 0},                 pass: 0, y: '{32, 32, 32, 32}};
    tbl[1] = '{x: '{64, 0, 0, 0},                 pass: 1, y: '{1, 1, 1, 1}};
    tbl[2] = '{x: '{0, 100, 0, 0},                pass: 0, y: '{65, 28, -28, -65}};
    tbl[3] = '{x: '{32767, 32767, 32767, 32767},  pass: 0, y: '{32767, -12032, 12032, 2304}};
    tbl[4] = '{x: '{-32768, -32768, -32768, -32768}, pass: 0, y: '{-32768, 12032, -12032, -2304}};
    tbl[5] = '{x: '{0, 0, 64, 0},                 pass: 1, y: '{1, -1, -1, 1}};
    tbl[6] = '{x: '{0, 0, 0, -100},               pass: 0, y: '{-28, 65, -65, 28}};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_pass  = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pass", int'(out_pass), 0);
    chk("rst_y", int'({y0, y1, y2, y3} == 64'd0), 1);
    chk("rst_in_ready", int'(in_ready), 1);
    reset_n = 1'b1;

    // Table vectors, back-to-back, always ready, latency checked.
    lat_en = 1'b1;
    for (int i = 0; i < 7; i++) send_vec(tbl[i]);
    idle();
    drain();

    // Stream of 8 alternating-pass vectors with a 4-cycle output stall.
    lat_en = 1'b0;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_model(100 * i - 300, 17 * i + 5, -40 * i, 1000 - 250 * i, i % 2);
        end
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        rdy_mode = 2;
        repeat (4) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();
    chk("stream_count", n_out - base, 8);

    // Asynchronous reset with three vectors in flight.
    send_vec(tbl[0]);
    send_vec(tbl[2]);
    send_vec(tbl[6]);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_y", int'({y0, y1, y2, y3} == 64'd0), 1);
    sb.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_out", int'(out_valid), 0);
    end
    lat_en = 1'b1;
    send_vec(tbl[1]);
    idle();
    drain();

    // Random vectors, both passes, random output back-pressure.
    lat_en = 1'b0;
    rdy_mode = 1;
    base = n_out;
    for (int i = 0; i < 10000; i++) begin
      send_model($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                 $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                 $urandom_range(0, 1));
    end
    idle();
    drain();
    chk("random_count", n_out - base, 10000);
    chk("total_count", n_out, n_sent - 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
